// File: rtl/vga_capture.sv
// vga_capture: recovers frame position from hs/vs rising edges of a VGA stream,
// verifies edge spacing, and once locked emits one frame-buffer write per active
// pixel addressed by row/col.
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_START  = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 34,
  parameter int V_ACTIVE = 480
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        wr_en,
  output logic [8:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_err
);
  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0]  CNT_MAX  = 10'h3FF;
  localparam logic [10:0] H_TOT    = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
  localparam logic [9:0]  H_FIRST  = 10'(H_START);
  localparam logic [9:0]  H_LAST   = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST  = 10'(V_START);
  localparam logic [9:0]  V_LAST   = 10'(V_START + V_ACTIVE - 1);
  localparam logic [8:0]  V_FIRST9 = 9'(V_START);

  state_t      state;
  logic        hs_q, hs_qq, vs_q, vs_qq;
  logic [11:0] rgb_q;
  logic        hs_rise, vs_rise;
  logic [9:0]  px, line, px_cur, line_cur;
  logic        seen_hs;
  logic        line_err, frame_err, err, cap;
  logic [9:0]  col_off;
  logic [8:0]  row_off;

  // input stage: syncs idle high so reset never fakes a rising edge
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      hs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs;
      hs_qq <= hs_q;
      vs_q  <= vs;
      vs_qq <= vs_q;
      rgb_q <= {r, g, b};
    end
  end

  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;

  // position of the pixel sitting in rgb_q this cycle; vs restart wins over hs step
  always_comb begin
    px_cur = (px == CNT_MAX) ? CNT_MAX : px + 10'd1;
    if (hs_rise) px_cur = '0;
    line_cur = line;
    if (vs_rise)                         line_cur = '0;
    else if (hs_rise && line != CNT_MAX) line_cur = line + 10'd1;
  end

  // saturating position counters
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      px   <= '0;
      line <= '0;
    end else begin
      px   <= px_cur;
      line <= line_cur;
    end
  end

  // edge-spacing checks; frame count includes an hs edge landing with vs
  always_comb begin
    line_err  = hs_rise && seen_hs && (({1'b0, px} + 11'd1) != H_TOT);
    frame_err = vs_rise && (({1'b0, line} + {10'd0, hs_rise}) != V_TOT);
    err       = (state != SEARCH) && (line_err || frame_err);
  end

  // capture gate also excludes the error cycle, since the drop to SEARCH is registered
  always_comb begin
    cap = (state == LOCKED) && !err &&
          (px_cur >= H_FIRST) && (px_cur <= H_LAST) &&
          (line_cur >= V_FIRST) && (line_cur <= V_LAST);
    col_off = px_cur - H_FIRST;
    row_off = line_cur[8:0] - V_FIRST9;
  end

  // lock FSM; locked and sync_err track the transition so they move together
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state    <= SEARCH;
      locked   <= 1'b0;
      sync_err <= 1'b0;
      seen_hs  <= 1'b0;
    end else begin
      sync_err <= err;
      if (err)          seen_hs <= 1'b0;
      else if (hs_rise) seen_hs <= 1'b1;
      case (state)
        SEARCH: begin
          locked <= 1'b0;
          if (vs_rise) state <= MEASURE;
        end
        MEASURE: begin
          if (err) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end else if (vs_rise) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (err) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // frame-buffer write port; address/data hold between writes
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= cap;
      frame_done <= cap && (px_cur == H_LAST) && (line_cur == V_LAST);
      if (cap) begin
        wr_col  <= col_off;
        wr_row  <= row_off;
        wr_data <= rgb_q;
      end
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scaled-down VGA timing (40x20 clocks) driving vga_capture.
module tb_vga_capture;
  localparam int HT = 40, VT = 20, HS0 = 6, HA = 24, VS0 = 4, VA = 12;
  localparam int HSW = 4, VSW = 2;

  logic vga_clk = 1'b0, clrn = 1'b1, hs = 1'b1, vs = 1'b1;
  logic [3:0] r = '0, g = '0, b = '0;
  logic wr_en, locked, frame_done, sync_err;
  logic [8:0] wr_row;
  logic [9:0] wr_col;
  logic [11:0] wr_data;

  vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS0), .H_ACTIVE(HA),
                .V_START(VS0), .V_ACTIVE(VA)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .locked(locked), .frame_done(frame_done), .sync_err(sync_err));

  always #20 vga_clk = ~vga_clk;

  int n_tests = 0, n_fail = 0;

  // stream generator state
  int hc = 0, vc = 0, frame = 0, h_len = HT, v_len = VT;
  bit coinc = 1'b0;

  task automatic drive();
    int row, col;
    logic [11:0] pxv;
    logic vs_low;
    hs = (hc >= HSW);
    if (coinc) vs_low = (vc == 0 && hc >= HSW) || (vc > 0 && vc < VSW) || (vc == VSW && hc < HSW);
    else       vs_low = (vc < VSW);
    vs  = !vs_low;
    row = vc - (coinc ? VSW + VS0 : VSW + VS0 - 1);
    col = hc - (HSW + HS0);
    if (row >= 0 && row < VA && col >= 0 && col < HA) pxv = {row[3:0], col[3:0], 4'h5};
    else pxv = 12'hABC;
    {r, g, b} = pxv;
  endtask

  task automatic gen_init(input bit c);
    coinc = c; hc = 0; vc = 0; frame = 0; h_len = HT; v_len = VT;
    drive();
  endtask

  task automatic tick();
    @(posedge vga_clk); #1;
    if (hc >= h_len - 1) begin
      hc = 0; h_len = HT;
      if (vc >= v_len - 1) begin vc = 0; v_len = VT; frame++; end
      else vc++;
    end else hc++;
    drive();
  endtask

  task automatic run_to(input int f, input int v, input int h);
    int guard = 0;
    do begin tick(); guard++; end while (!(frame == f && vc == v && hc == h) && guard < 10000);
    if (guard >= 10000) begin
      n_tests++; n_fail++;
      $display("FAIL run_to_timeout: at f%0d v%0d h%0d, wanted f%0d v%0d h%0d", frame, vc, hc, f, v, h);
    end
  endtask

  task automatic pulse_reset(input bit c);
    clrn = 1'b0;
    gen_init(c);
    repeat (2) @(posedge vga_clk);
    #1 clrn = 1'b1;
  endtask

  // write-port observer
  int wr_cnt = 0, data_bad = 0, range_bad = 0, fd_bad = 0, fd_cnt = 0, se_cnt = 0, se_long = 0;
  int cnt_at_err = 0;
  bit first_pend = 1'b0, se_prev = 1'b0, lock_prev = 1'b0, lock_at_err = 1'b0, lock_before_err = 1'b0;
  logic [8:0] f_row = '0, l_row = '0;
  logic [9:0] f_col = '0, l_col = '0;
  logic [11:0] f_data = '0;
  logic l_fd = 1'b0;

  always @(negedge vga_clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (first_pend) begin f_row = wr_row; f_col = wr_col; f_data = wr_data; first_pend = 1'b0; end
      l_row = wr_row; l_col = wr_col; l_fd = frame_done;
      if (wr_data !== {wr_row[3:0], wr_col[3:0], 4'h5}) data_bad++;
      if (wr_row >= VA || wr_col >= HA) range_bad++;
    end
    if (frame_done !== (wr_en && wr_row == VA - 1 && wr_col == HA - 1)) fd_bad++;
    if (frame_done) fd_cnt++;
    if (sync_err) begin
      se_cnt++;
      if (se_prev) se_long++;
      lock_at_err = locked; lock_before_err = lock_prev; cnt_at_err = wr_cnt;
    end
    se_prev = sync_err; lock_prev = locked;
  end

  task automatic test_reset();
    clrn = 1'b0;
    gen_init(1'b0);
    repeat (3) @(posedge vga_clk);
    #1;
    n_tests++; if ({wr_en, locked, frame_done, sync_err} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {wr_en, locked, frame_done, sync_err}); end
    n_tests++; if ({wr_row, wr_col, wr_data} !== 31'd0) begin n_fail++;
      $display("FAIL reset_addr: got %h want 0", {wr_row, wr_col, wr_data}); end
    clrn = 1'b1;
  endtask

  task automatic test_nominal();
    int c0, fd0;
    c0 = wr_cnt;
    run_to(1, 0, 0);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL nom_unlocked_f0: got %b want 0", locked); end
    n_tests++; if (wr_cnt - c0 !== 0) begin n_fail++; $display("FAIL nom_writes_f0: got %0d want 0", wr_cnt - c0); end
    run_to(1, 2, 0);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL nom_lock_early: got %b want 0", locked); end
    run_to(1, 2, 3);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL nom_lock_rise: got %b want 1", locked); end
    c0 = wr_cnt; fd0 = fd_cnt; first_pend = 1'b1;
    run_to(2, 0, 0);
    n_tests++; if (wr_cnt - c0 !== HA * VA) begin n_fail++; $display("FAIL nom_write_count: got %0d want %0d", wr_cnt - c0, HA * VA); end
    n_tests++; if ({f_row, f_col, f_data} !== {9'd0, 10'd0, 12'h005}) begin n_fail++;
      $display("FAIL nom_first_write: got r%0d c%0d d%h want r0 c0 d005", f_row, f_col, f_data); end
    n_tests++; if ({l_row, l_col, l_fd} !== {9'd11, 10'd23, 1'b1}) begin n_fail++;
      $display("FAIL nom_last_write: got r%0d c%0d fd%b want r11 c23 fd1", l_row, l_col, l_fd); end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL nom_frame_done: got %0d want 1", fd_cnt - fd0); end
    n_tests++; if (se_cnt !== 0) begin n_fail++; $display("FAIL nom_no_err: got %0d want 0", se_cnt); end
  endtask

  task automatic test_short_line();
    int c0, s0;
    c0 = wr_cnt; s0 = se_cnt;
    run_to(2, 7, 1);
    h_len = HT - 1;
    run_to(3, 0, 0);
    n_tests++; if (se_cnt - s0 !== 1) begin n_fail++; $display("FAIL short_err_count: got %0d want 1", se_cnt - s0); end
    n_tests++; if (se_long !== 0) begin n_fail++; $display("FAIL short_err_width: got %0d long pulses want 0", se_long); end
    n_tests++; if ({lock_before_err, lock_at_err} !== 2'b10) begin n_fail++;
      $display("FAIL short_lock_drop: got before/at %b want 10", {lock_before_err, lock_at_err}); end
    n_tests++; if (wr_cnt - c0 !== 3 * HA) begin n_fail++; $display("FAIL short_writes: got %0d want %0d", wr_cnt - c0, 3 * HA); end
    n_tests++; if (wr_cnt !== cnt_at_err) begin n_fail++; $display("FAIL short_post_err_writes: got %0d want %0d", wr_cnt, cnt_at_err); end
    c0 = wr_cnt;
    run_to(4, 0, 0);
    n_tests++; if ({locked, 32'(wr_cnt - c0)} !== {1'b0, 32'd0}) begin n_fail++;
      $display("FAIL short_measure: got lock %b writes %0d want 0 0", locked, wr_cnt - c0); end
    run_to(5, 0, 0);
    n_tests++; if ({locked, 32'(wr_cnt - c0)} !== {1'b1, 32'(HA * VA)}) begin n_fail++;
      $display("FAIL short_relock: got lock %b writes %0d want 1 %0d", locked, wr_cnt - c0, HA * VA); end
  endtask

  task automatic test_frame_len();
    int c0, s0;
    pulse_reset(1'b0);
    v_len = VT - 1;
    c0 = wr_cnt; s0 = se_cnt;
    run_to(1, 3, 0);
    n_tests++; if (se_cnt - s0 !== 1) begin n_fail++; $display("FAIL flen_err: got %0d want 1", se_cnt - s0); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL flen_unlocked: got %b want 0", locked); end
    run_to(3, 0, 0);
    n_tests++; if (wr_cnt - c0 !== 0) begin n_fail++; $display("FAIL flen_writes: got %0d want 0", wr_cnt - c0); end
    run_to(4, 0, 0);
    n_tests++; if ({locked, 32'(wr_cnt - c0)} !== {1'b1, 32'(HA * VA)}) begin n_fail++;
      $display("FAIL flen_relock: got lock %b writes %0d want 1 %0d", locked, wr_cnt - c0, HA * VA); end
  endtask

  task automatic test_reset_mid();
    int c0;
    run_to(4, 10, 20);
    clrn = 1'b0;
    #1;
    n_tests++; if ({wr_en, locked, frame_done, sync_err, wr_row, wr_col, wr_data} !== 35'd0) begin n_fail++;
      $display("FAIL rst_mid_clear: got %h want 0", {wr_en, locked, frame_done, sync_err, wr_row, wr_col, wr_data}); end
    repeat (3) tick();
    n_tests++; if ({wr_en, locked, wr_row, wr_col} !== 21'd0) begin n_fail++;
      $display("FAIL rst_mid_hold: got %h want 0", {wr_en, locked, wr_row, wr_col}); end
    clrn = 1'b1;
    c0 = wr_cnt; first_pend = 1'b1;
    run_to(6, 0, 0);
    n_tests++; if (wr_cnt - c0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_partial: got %0d want 0", wr_cnt - c0); end
    run_to(7, 0, 0);
    n_tests++; if (wr_cnt - c0 !== HA * VA) begin n_fail++; $display("FAIL rst_mid_frame: got %0d want %0d", wr_cnt - c0, HA * VA); end
    n_tests++; if ({f_row, f_col, f_data} !== {9'd0, 10'd0, 12'h005}) begin n_fail++;
      $display("FAIL rst_mid_first: got r%0d c%0d d%h want r0 c0 d005", f_row, f_col, f_data); end
  endtask

  task automatic test_coincident();
    int c0, s0;
    pulse_reset(1'b1);
    c0 = wr_cnt; s0 = se_cnt;
    run_to(1, 2, 4);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL coinc_lock_early: got %b want 0", locked); end
    run_to(1, 2, 8);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL coinc_lock: got %b want 1", locked); end
    n_tests++; if (wr_cnt - c0 !== 0) begin n_fail++; $display("FAIL coinc_f0_writes: got %0d want 0", wr_cnt - c0); end
    c0 = wr_cnt; first_pend = 1'b1;
    run_to(2, 0, 0);
    n_tests++; if (wr_cnt - c0 !== HA * VA) begin n_fail++; $display("FAIL coinc_writes: got %0d want %0d", wr_cnt - c0, HA * VA); end
    n_tests++; if ({f_row, f_col, f_data} !== {9'd0, 10'd0, 12'h005}) begin n_fail++;
      $display("FAIL coinc_first: got r%0d c%0d d%h want r0 c0 d005", f_row, f_col, f_data); end
    n_tests++; if ({l_row, l_col, l_fd} !== {9'd11, 10'd23, 1'b1}) begin n_fail++;
      $display("FAIL coinc_last: got r%0d c%0d fd%b want r11 c23 fd1", l_row, l_col, l_fd); end
    n_tests++; if (se_cnt - s0 !== 0) begin n_fail++; $display("FAIL coinc_no_err: got %0d want 0", se_cnt - s0); end
  endtask

  task automatic test_inactive_region();
    n_tests++; if (data_bad !== 0) begin n_fail++; $display("FAIL inact_data: got %0d bad writes want 0", data_bad); end
    n_tests++; if (range_bad !== 0) begin n_fail++; $display("FAIL inact_range: got %0d out-of-range writes want 0", range_bad); end
    n_tests++; if (fd_bad !== 0) begin n_fail++; $display("FAIL inact_frame_done: got %0d misplaced pulses want 0", fd_bad); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_frame_len();
    test_reset_mid();
    test_coincident();
    test_inactive_region();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
